// File: rtl/capture_ctrl_pkg.sv
// Shared types and defaults for the ADC capture controller.
package capture_ctrl_pkg;
  localparam int AW_DEF = 15;
  localparam int DW_DEF = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } cap_state_e;
endpackage

// File: rtl/capture_ctrl_if.sv
// Dual-port capture memory bus: write side from the FSM, read side from readback.
interface capture_ctrl_if import capture_ctrl_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic          wen;
  logic [AW-1:0] waddr;
  logic          ren;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata;

  modport master (output wen, waddr, ren, raddr, input rdata);
  modport slave  (input wen, waddr, ren, raddr, output rdata);
endinterface

// File: rtl/capture_rdback.sv
// MDIO readback: registered read strobe, then capture of memory data one cycle later.
module capture_rdback import capture_ctrl_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          read_pulse,
  input  logic [AW-1:0] read_addr,
  output logic          ren,
  output logic [AW-1:0] raddr,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid
);
  localparam int STAGES = 2;

  // [1]: strobe on the memory, [2]: memory data present this cycle
  logic [STAGES:1] vld_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      raddr    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], read_pulse};
      if (read_pulse) raddr <= read_addr;
      rd_valid <= vld_pipe[STAGES];
      if (vld_pipe[STAGES]) rd_data <= rdata;
    end
  end

  assign ren = vld_pipe[1];
endmodule

// File: rtl/capture_ctrl.sv
// ADC capture controller: edge-driven FSM filling a capture memory, plus MDIO readback.
module capture_ctrl import capture_ctrl_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rf_capture_mode,
  input  logic            rf_capture_start,
  input  logic            rf_capture_again,
  input  logic            adc_vld,
  capture_ctrl_if.master  mem,
  input  logic            rf_mdio_read_pulse,
  input  logic [AW-1:0]   rf_mdio_memory_addr,
  output logic [DW-1:0]   mdio_rd_data,
  output logic            mdio_rd_valid,
  output logic            capture_busy,
  output logic            capture_done,
  output logic            capture_wrap
);
  localparam logic [AW-1:0] PTR_MAX = '1;

  cap_state_e    state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic          wrap, wrap_nxt;
  logic          start_q, again_q;
  logic          start_rise, start_fall, again_rise;
  logic          wen;

  assign start_rise = rf_capture_start & ~start_q;
  assign start_fall = ~rf_capture_start & start_q;
  assign again_rise = rf_capture_again & ~again_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      wrap    <= 1'b0;
      start_q <= 1'b0;
      again_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      wrap    <= wrap_nxt;
      start_q <= rf_capture_start;
      again_q <= rf_capture_again;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    wrap_nxt  = wrap;
    wen       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_rise) begin
          state_nxt = CAPTURE;
          ptr_nxt   = '0;
          wrap_nxt  = 1'b0;
        end
      end
      CAPTURE: begin
        wen = adc_vld;
        if (adc_vld) begin
          if (ptr == PTR_MAX) begin
            // single-shot parks on the last address; continuous rolls over
            if (rf_capture_mode) begin
              ptr_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            ptr_nxt = ptr + 1'b1;
          end
        end
        if (start_fall) state_nxt = DONE;
      end
      DONE: begin
        if (start_fall) begin
          state_nxt = IDLE;
        end else if (again_rise) begin
          state_nxt = CAPTURE;
          ptr_nxt   = '0;
          wrap_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem.wen      = wen;
  assign mem.waddr    = ptr;
  assign capture_busy = (state == CAPTURE);
  assign capture_done = (state == DONE);
  assign capture_wrap = wrap;

  capture_rdback #(.AW(AW), .DW(DW)) u_rdback (
    .clk        (clk),
    .rst        (rst),
    .read_pulse (rf_mdio_read_pulse),
    .read_addr  (rf_mdio_memory_addr),
    .ren        (mem.ren),
    .raddr      (mem.raddr),
    .rdata      (mem.rdata),
    .rd_data    (mdio_rd_data),
    .rd_valid   (mdio_rd_valid)
  );
endmodule

// File: tb/tb_capture_ctrl.sv
// Directed + randomized bench for capture_ctrl with AW=4; includes a behavioural capture memory.
module tb_capture_ctrl;
  import capture_ctrl_pkg::*;
  localparam int AW = 4;
  localparam int DW = 9;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0, rst = 1'b1;
  logic          mode = 1'b0, start = 1'b0, again = 1'b0, vld = 1'b0;
  logic          rpulse = 1'b0;
  logic [AW-1:0] raddr_in = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, busy, done, wrap;

  capture_ctrl_if #(.AW(AW), .DW(DW)) mem_if ();

  capture_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rf_capture_mode     (mode),
    .rf_capture_start    (start),
    .rf_capture_again    (again),
    .adc_vld             (vld),
    .mem                 (mem_if),
    .rf_mdio_read_pulse  (rpulse),
    .rf_mdio_memory_addr (raddr_in),
    .mdio_rd_data        (rd_data),
    .mdio_rd_valid       (rd_valid),
    .capture_busy        (busy),
    .capture_done        (done),
    .capture_wrap        (wrap)
  );

  always #5 clk = ~clk;

  // memory model: random sample data on each write, one-cycle read latency
  logic [DW-1:0] mem [DEPTH];
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_addr = '0;
  logic [DW-1:0] poke_data = '0;
  always @(posedge clk) begin
    if (mem_if.wen) mem[mem_if.waddr] <= DW'($urandom);
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_if.ren) mem_if.rdata <= mem[mem_if.raddr];
  end

  int wq[$];
  always @(negedge clk) if (mem_if.wen === 1'b1) wq.push_back(int'(mem_if.waddr));

  int ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_busy(input string tag, input logic b);
    int k = 0;
    while (busy !== b && k < 8) begin tick(); k++; end
    chk(tag, 32'(busy), 32'(b));
  endtask

  // reference: n accepted samples give addresses k mod depth, single-shot stops at depth
  task automatic check_writes(input string tag, input int n, input logic m);
    int exp_n;
    exp_n = (m || n < DEPTH) ? n : DEPTH;
    chk({tag, "_count"}, 32'(wq.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wq.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), 32'(wq[i]), 32'(i % DEPTH));
  endtask

  task automatic drive_vld(input int n);
    vld = 1'b1;
    for (int i = 0; i < n; i++) tick();
    vld = 1'b0;
  endtask

  task automatic leave_done();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wen"}, 32'(mem_if.wen), 0);
    chk({tag, "_waddr"}, 32'(mem_if.waddr), 0);
    chk({tag, "_ren"}, 32'(mem_if.ren), 0);
    chk({tag, "_raddr"}, 32'(mem_if.raddr), 0);
    chk({tag, "_rdata"}, 32'(rd_data), 0);
    chk({tag, "_rvalid"}, 32'(rd_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_wrap"}, 32'(wrap), 0);
  endtask

  initial begin
    int nv, ncyc;
    logic m;
    logic [DW-1:0] e1, e2, e3;

    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0; tick();

    // single-shot fill: 20 samples, only 16 land
    wq.delete(); mode = 1'b0; start = 1'b1; tick();
    wait_busy("single_busy", 1'b1);
    drive_vld(20); tick();
    check_writes("single", 20, 1'b0);
    chk("single_done", 32'(done), 1);
    chk("single_notbusy", 32'(busy), 0);

    // re-arm from DONE restarts at address 0
    wq.delete(); again = 1'b1; tick();
    wait_busy("again_busy", 1'b1);
    chk("again_wrap", 32'(wrap), 0);
    again = 1'b0;
    drive_vld(5); tick();
    check_writes("again_part", 5, 1'b0);
    drive_vld(11); tick();
    check_writes("again_full", 16, 1'b0);
    chk("again_done", 32'(done), 1);

    // again rise and start fall together: start fall wins
    again = 1'b1; start = 1'b0; tick(); tick();
    chk("race_busy", 32'(busy), 0);
    chk("race_done", 32'(done), 0);
    wq.delete(); drive_vld(4); tick();
    chk("race_nowrite", 32'(wq.size()), 0);
    again = 1'b0; tick();

    // continuous: 20 samples wrap, stop keeps pointer
    wq.delete(); mode = 1'b1; start = 1'b1; tick();
    wait_busy("cont_busy", 1'b1);
    drive_vld(20); tick();
    check_writes("cont", 20, 1'b1);
    chk("cont_wrap", 32'(wrap), 1);
    start = 1'b0; tick();
    chk("cont_done", 32'(done), 1);
    chk("cont_ptr", 32'(dut.ptr), 4);
    leave_done();
    chk("cont_idle", 32'(done), 0);

    // single readback timing
    poke_en = 1'b1; poke_addr = 4'd5; poke_data = 9'h1A5; tick(); poke_en = 1'b0;
    rpulse = 1'b1; raddr_in = 4'd5; tick();
    rpulse = 1'b0; raddr_in = '0;
    chk("rd_ren_n1", 32'(mem_if.ren), 1);
    chk("rd_raddr_n1", 32'(mem_if.raddr), 5);
    chk("rd_valid_n1", 32'(rd_valid), 0);
    tick();
    chk("rd_ren_n2", 32'(mem_if.ren), 0);
    chk("rd_valid_n2", 32'(rd_valid), 0);
    tick();
    chk("rd_valid_n3", 32'(rd_valid), 1);
    chk("rd_data_n3", 32'(rd_data), 32'h1A5);
    tick();
    chk("rd_valid_n4", 32'(rd_valid), 0);

    // back-to-back reads during a continuous capture
    wq.delete(); mode = 1'b1; start = 1'b1; tick();
    wait_busy("b2b_busy", 1'b1);
    vld = 1'b1; nv = 0;
    for (int i = 0; i < 8; i++) begin tick(); nv++; end
    rpulse = 1'b1; raddr_in = 4'd1; e1 = mem[1]; tick(); nv++;
    raddr_in = 4'd2; e2 = mem[2]; tick(); nv++;
    raddr_in = 4'd3; e3 = mem[3]; tick(); nv++;
    rpulse = 1'b0; raddr_in = '0;
    chk("b2b_v1", 32'(rd_valid), 1); chk("b2b_d1", 32'(rd_data), 32'(e1));
    tick(); nv++;
    chk("b2b_v2", 32'(rd_valid), 1); chk("b2b_d2", 32'(rd_data), 32'(e2));
    tick(); nv++;
    chk("b2b_v3", 32'(rd_valid), 1); chk("b2b_d3", 32'(rd_data), 32'(e3));
    tick(); nv++;
    chk("b2b_v4", 32'(rd_valid), 0);
    vld = 1'b0; tick();
    check_writes("b2b_wr", nv, 1'b1);
    start = 1'b0; tick(); leave_done();

    // randomized captures
    for (int it = 0; it < 6; it++) begin
      m = 1'($urandom % 2);
      wq.delete(); mode = m; start = 1'b1; tick();
      wait_busy($sformatf("rnd%0d_busy", it), 1'b1);
      nv = 0; ncyc = 10 + int'($urandom % 30);
      for (int c = 0; c < ncyc; c++) begin
        vld = 1'($urandom % 2);
        tick();
        if (vld) nv++;
      end
      vld = 1'b0; tick();
      check_writes($sformatf("rnd%0d", it), nv, m);
      if (m) chk($sformatf("rnd%0d_wrap", it), 32'(wrap), 32'(nv >= DEPTH));
      start = 1'b0; tick();
      if (!m && nv >= DEPTH) begin
        chk($sformatf("rnd%0d_idle", it), 32'(done | busy), 0);
      end else begin
        chk($sformatf("rnd%0d_done", it), 32'(done), 1);
        chk($sformatf("rnd%0d_ptr", it), 32'(dut.ptr), 32'(m ? nv % DEPTH : nv));
        leave_done();
      end
    end

    // asynchronous reset in the middle of a capture
    wq.delete(); mode = 1'b0; start = 1'b1; tick();
    wait_busy("rst_busy", 1'b1);
    drive_vld(7);
    chk("rst_prewrites", 32'(wq.size()), 7);
    vld = 1'b1; #2; rst = 1'b1; #1;
    check_all_zero("rst_mid");
    start = 1'b0; tick(); rst = 1'b0; vld = 1'b0; tick();
    wq.delete(); start = 1'b1; tick();
    wait_busy("rst_restart", 1'b1);
    drive_vld(1); tick();
    check_writes("rst_restart", 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
